// File: rtl/writeback_stage.sv
// Writeback stage: W pipeline register, committed register-file write
// ports, sticky run/halt/error status and a retired-instruction counter.
//
// Ports:
//   clk_i, rst_i               clock, synchronous active-high reset
//   W_stall_i, W_bubble_i      W register hold / bubble insert
//   m_stat_i, M_icode_i,
//   M_dstE_i, M_valE_i,
//   M_dstM_i, m_valM_i         memory-stage results loaded into W
//   W_*_o                      raw W register fields (forwarding sources)
//   w_dstE_o, w_valE_o,
//   w_dstM_o, w_valM_o         committed register writes (RNONE = none)
//   stat_o, halted_o           processor status
//   retired_o                  retired-instruction count
module writeback_stage #(
  parameter logic [3:0] RNONE = 4'hF,
  parameter logic [3:0] INOP  = 4'h1,
  parameter logic [3:0] SAOK  = 4'd1,
  parameter logic [3:0] SHLT  = 4'd2,
  parameter logic [3:0] SADR  = 4'd3,
  parameter logic [3:0] SINS  = 4'd4,
  parameter int         CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             W_stall_i,
  input  logic             W_bubble_i,
  input  logic [3:0]       m_stat_i,
  input  logic [3:0]       M_icode_i,
  input  logic [3:0]       M_dstE_i,
  input  logic [63:0]      M_valE_i,
  input  logic [3:0]       M_dstM_i,
  input  logic [63:0]      m_valM_i,
  output logic [3:0]       W_stat_o,
  output logic [3:0]       W_icode_o,
  output logic [3:0]       W_dstE_o,
  output logic [63:0]      W_valE_o,
  output logic [3:0]       W_dstM_o,
  output logic [63:0]      W_valM_o,
  output logic [3:0]       w_dstE_o,
  output logic [63:0]      w_valE_o,
  output logic [3:0]       w_dstM_o,
  output logic [63:0]      w_valM_o,
  output logic [3:0]       stat_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] retired_o
);

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_HALT = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  logic [3:0]       w_stat;
  logic [3:0]       w_icode;
  logic [3:0]       w_dste;
  logic [63:0]      w_vale;
  logic [3:0]       w_dstm;
  logic [63:0]      w_valm;
  logic [1:0]       state;
  logic [3:0]       stat_q;
  logic [CNT_W-1:0] retired_q;

  logic running;
  logic commit;
  logic collide;
  logic retire;

  assign running = (state == ST_RUN);
  assign commit  = running && (w_stat == SAOK);
  // Both ports naming the same register: the M port wins.
  assign collide = (w_dste == w_dstm) && (w_dstm != RNONE);
  assign retire  = commit && (w_icode != INOP) && !W_stall_i;

  always_ff @(posedge clk_i) begin
    if (rst_i || W_bubble_i) begin
      w_stat  <= SAOK;
      w_icode <= INOP;
      w_dste  <= RNONE;
      w_vale  <= '0;
      w_dstm  <= RNONE;
      w_valm  <= '0;
    end else if (!W_stall_i) begin
      w_stat  <= m_stat_i;
      w_icode <= M_icode_i;
      w_dste  <= M_dstE_i;
      w_vale  <= M_valE_i;
      w_dstm  <= M_dstM_i;
      w_valm  <= m_valM_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_RUN;
      stat_q <= SAOK;
    end else if (running) begin
      unique case (1'b1)
        (w_stat == SHLT): begin
          state  <= ST_HALT;
          stat_q <= SHLT;
        end
        (w_stat == SADR),
        (w_stat == SINS): begin
          state  <= ST_ERR;
          stat_q <= w_stat;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      retired_q <= '0;
    else if (retire)
      retired_q <= retired_q + 1'b1;
  end

  assign W_stat_o  = w_stat;
  assign W_icode_o = w_icode;
  assign W_dstE_o  = w_dste;
  assign W_valE_o  = w_vale;
  assign W_dstM_o  = w_dstm;
  assign W_valM_o  = w_valm;

  assign w_dstE_o  = (commit && !collide) ? w_dste : RNONE;
  assign w_dstM_o  = commit ? w_dstm : RNONE;
  assign w_valE_o  = w_vale;
  assign w_valM_o  = w_valm;

  assign stat_o    = stat_q;
  assign halted_o  = !running;
  assign retired_o = retired_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios plus random traffic
// against a behavioural model of the W register and processor status.
module tb_writeback_stage;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, stall, bubble;
  logic [3:0]  m_stat, m_icode, m_dste, m_dstm;
  logic [63:0] m_vale, m_valm;

  logic [3:0]  W_stat, W_icode, W_dstE, W_dstM;
  logic [63:0] W_valE, W_valM;
  logic [3:0]  w_dstE, w_dstM, stat_o;
  logic [63:0] w_valE, w_valM;
  logic        halted;
  logic [63:0] retired;

  logic [3:0]  b_W_stat, b_W_icode, b_W_dstE, b_W_dstM;
  logic [63:0] b_W_valE, b_W_valM;
  logic [3:0]  b_w_dstE, b_w_dstM, b_stat;
  logic [63:0] b_w_valE, b_w_valM;
  logic        b_halted;
  logic [3:0]  b_retired;

  writeback_stage dut (
    .clk_i(clk), .rst_i(rst),
    .W_stall_i(stall), .W_bubble_i(bubble),
    .m_stat_i(m_stat), .M_icode_i(m_icode),
    .M_dstE_i(m_dste), .M_valE_i(m_vale),
    .M_dstM_i(m_dstm), .m_valM_i(m_valm),
    .W_stat_o(W_stat), .W_icode_o(W_icode),
    .W_dstE_o(W_dstE), .W_valE_o(W_valE),
    .W_dstM_o(W_dstM), .W_valM_o(W_valM),
    .w_dstE_o(w_dstE), .w_valE_o(w_valE),
    .w_dstM_o(w_dstM), .w_valM_o(w_valM),
    .stat_o(stat_o), .halted_o(halted),
    .retired_o(retired)
  );

  writeback_stage #(.CNT_W(4)) dut4 (
    .clk_i(clk), .rst_i(rst),
    .W_stall_i(stall), .W_bubble_i(bubble),
    .m_stat_i(m_stat), .M_icode_i(m_icode),
    .M_dstE_i(m_dste), .M_valE_i(m_vale),
    .M_dstM_i(m_dstm), .m_valM_i(m_valm),
    .W_stat_o(b_W_stat), .W_icode_o(b_W_icode),
    .W_dstE_o(b_W_dstE), .W_valE_o(b_W_valE),
    .W_dstM_o(b_W_dstM), .W_valM_o(b_W_valM),
    .w_dstE_o(b_w_dstE), .w_valE_o(b_w_valE),
    .w_dstM_o(b_w_dstM), .w_valM_o(b_w_valM),
    .stat_o(b_stat), .halted_o(b_halted),
    .retired_o(b_retired)
  );

  int total = 0;
  int bad = 0;

  // Model: the instruction sitting in W, processor status, retire count.
  logic [3:0]  md_stat, md_icode, md_dste, md_dstm;
  logic [63:0] md_vale, md_valm;
  logic [3:0]  mstatus;
  logic [63:0] mret;

  task automatic drive(input logic [3:0] st, input logic [3:0] ic,
                       input logic [3:0] de, input logic [63:0] ve,
                       input logic [3:0] dm, input logic [63:0] vm);
    m_stat = st; m_icode = ic;
    m_dste = de; m_vale = ve;
    m_dstm = dm; m_valm = vm;
  endtask

  task automatic step();
    @(posedge clk);
    if (rst) begin
      md_stat = 1; md_icode = 1;
      md_dste = 4'hF; md_dstm = 4'hF;
      md_vale = 0; md_valm = 0;
      mstatus = 1; mret = 0;
    end else begin
      if (mstatus == 1 && md_stat == 1 && md_icode != 1 && !stall)
        mret = mret + 1;
      if (mstatus == 1 && md_stat == 2)
        mstatus = 2;
      else if (mstatus == 1 && (md_stat == 3 || md_stat == 4))
        mstatus = md_stat;
      if (bubble) begin
        md_stat = 1; md_icode = 1;
        md_dste = 4'hF; md_dstm = 4'hF;
        md_vale = 0; md_valm = 0;
      end else if (!stall) begin
        md_stat = m_stat; md_icode = m_icode;
        md_dste = m_dste; md_vale = m_vale;
        md_dstm = m_dstm; md_valm = m_valm;
      end
    end
    #1;
  endtask

  task automatic nop_in();
    drive(1, 1, 4'hF, 0, 4'hF, 0);
  endtask

  task automatic do_reset();
    rst = 1; stall = 0; bubble = 0;
    nop_in();
    step(); step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (W_icode !== 4'h1 || W_stat !== 4'h1) begin
      bad++;
      $display("FAIL reset_W icode=%h stat=%h want 1 1", W_icode, W_stat);
    end
    total++;
    if (W_dstE !== 4'hF || W_dstM !== 4'hF || w_dstE !== 4'hF) begin
      bad++;
      $display("FAIL reset_dst %h %h %h want F F F", W_dstE, W_dstM, w_dstE);
    end
    total++;
    if (stat_o !== 4'h1 || halted !== 1'b0 || retired !== 64'd0) begin
      bad++;
      $display("FAIL reset_stat stat=%h halt=%b ret=%0d want 1 0 0",
               stat_o, halted, retired);
    end
  endtask

  task automatic test_normal_load();
    drive(1, 6, 3, 64'h55, 4'hF, 0);
    step();
    total++;
    if (w_dstE !== 4'h3 || w_valE !== 64'h55 || w_dstM !== 4'hF) begin
      bad++;
      $display("FAIL load dstE=%h valE=%h dstM=%h want 3 55 F",
               w_dstE, w_valE, w_dstM);
    end
    nop_in();
    step();
    total++;
    if (retired !== 64'd1) begin
      bad++;
      $display("FAIL load_retire got %0d want 1", retired);
    end
  endtask

  task automatic test_collision();
    drive(1, 4'hB, 4, 64'h10, 4, 64'h20);
    step();
    total++;
    if (w_dstM !== 4'h4 || w_valM !== 64'h20 || w_dstE !== 4'hF) begin
      bad++;
      $display("FAIL collision dstM=%h valM=%h dstE=%h want 4 20 F",
               w_dstM, w_valM, w_dstE);
    end
  endtask

  task automatic test_stall_bubble();
    logic [63:0] r0;
    drive(1, 6, 1, 64'h7, 4'hF, 0);
    step();
    r0 = mret;
    stall = 1;
    drive(1, 6, 1, 64'h9, 4'hF, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (W_valE !== 64'h7 || retired !== r0) begin
        bad++;
        $display("FAIL stall[%0d] valE=%h ret=%0d want 7 %0d",
                 i, W_valE, retired, r0);
      end
    end
    bubble = 1;
    step();
    total++;
    if (W_icode !== 4'h1 || W_dstE !== 4'hF) begin
      bad++;
      $display("FAIL bubble_over_stall icode=%h dstE=%h want 1 F",
               W_icode, W_dstE);
    end
    stall = 0; bubble = 0;
  endtask

  task automatic test_halt();
    logic [63:0] r0;
    drive(2, 0, 2, 64'h1, 4'hF, 0);
    step();
    total++;
    if (w_dstE !== 4'hF || stat_o !== 4'h1 || halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_insn dstE=%h stat=%h halt=%b want F 1 0",
               w_dstE, stat_o, halted);
    end
    drive(1, 6, 5, 64'h2, 4'hF, 0);
    step();
    r0 = mret;
    total++;
    if (stat_o !== 4'h2 || halted !== 1'b1 || w_dstE !== 4'hF) begin
      bad++;
      $display("FAIL halted stat=%h halt=%b dstE=%h want 2 1 F",
               stat_o, halted, w_dstE);
    end
    step(); step();
    total++;
    if (retired !== r0 || w_dstE !== 4'hF || stat_o !== 4'h2) begin
      bad++;
      $display("FAIL halt_frozen ret=%0d dstE=%h stat=%h want %0d F 2",
               retired, w_dstE, stat_o, r0);
    end
    do_reset();
    total++;
    if (stat_o !== 4'h1 || halted !== 1'b0) begin
      bad++;
      $display("FAIL halt_reset stat=%h halt=%b want 1 0", stat_o, halted);
    end
  endtask

  task automatic test_error();
    drive(3, 5, 6, 64'h3, 7, 64'h4);
    step();
    total++;
    if (w_dstE !== 4'hF || w_dstM !== 4'hF) begin
      bad++;
      $display("FAIL err_insn dstE=%h dstM=%h want F F", w_dstE, w_dstM);
    end
    drive(4, 6, 2, 64'h5, 4'hF, 0);
    step();
    total++;
    if (stat_o !== 4'h3 || halted !== 1'b1) begin
      bad++;
      $display("FAIL error stat=%h halt=%b want 3 1", stat_o, halted);
    end
    drive(2, 6, 2, 64'h5, 4'hF, 0);
    step(); step();
    total++;
    if (stat_o !== 4'h3 || halted !== 1'b1) begin
      bad++;
      $display("FAIL error_sticky stat=%h halt=%b want 3 1", stat_o, halted);
    end
    do_reset();
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 6, 4'(i), 64'(i), 4'hF, 0);
      step();
    end
    nop_in();
    step();
    total++;
    if (b_retired !== 4'd1 || retired !== 64'd17) begin
      bad++;
      $display("FAIL wrap ret4=%0d ret64=%0d want 1 17", b_retired, retired);
    end
  endtask

  task automatic test_random();
    logic        cm;
    logic [3:0]  ede, edm;
    int          r;
    for (int i = 0; i < 600; i++) begin
      rst    = ($urandom_range(0, 59) == 0);
      stall  = ($urandom_range(0, 4) == 0);
      bubble = ($urandom_range(0, 6) == 0);
      r = $urandom_range(0, 49);
      m_stat  = (r == 0) ? 4'd2 : (r == 1) ? 4'd3 :
                (r == 2) ? 4'd4 : (r == 3) ? 4'd0 : 4'd1;
      m_icode = 4'($urandom);
      m_dste  = 4'($urandom);
      m_dstm  = ($urandom_range(0, 3) == 0) ? m_dste : 4'($urandom);
      m_vale  = {$urandom, $urandom};
      m_valm  = {$urandom, $urandom};
      step();
      cm  = (mstatus == 1) && (md_stat == 1);
      edm = cm ? md_dstm : 4'hF;
      ede = (cm && !(md_dste == md_dstm && md_dstm != 4'hF)) ?
            md_dste : 4'hF;
      total++;
      if ({W_stat, W_icode, W_dstE, W_valE, W_dstM, W_valM} !==
          {md_stat, md_icode, md_dste, md_vale, md_dstm, md_valm}) begin
        bad++;
        $display("FAIL rnd_W[%0d] got %h %h %h %h %h %h want %h %h %h %h %h %h",
                 i, W_stat, W_icode, W_dstE, W_valE, W_dstM, W_valM,
                 md_stat, md_icode, md_dste, md_vale, md_dstm, md_valm);
      end
      total++;
      if ({w_dstE, w_valE, w_dstM, w_valM} !==
          {ede, md_vale, edm, md_valm}) begin
        bad++;
        $display("FAIL rnd_commit[%0d] got %h %h %h %h want %h %h %h %h",
                 i, w_dstE, w_valE, w_dstM, w_valM,
                 ede, md_vale, edm, md_valm);
      end
      total++;
      if (stat_o !== mstatus || halted !== (mstatus != 1)) begin
        bad++;
        $display("FAIL rnd_stat[%0d] got %h %b want %h %b",
                 i, stat_o, halted, mstatus, mstatus != 1);
      end
      total++;
      if (retired !== mret || b_retired !== mret[3:0]) begin
        bad++;
        $display("FAIL rnd_retired[%0d] got %0d %0d want %0d %0d",
                 i, retired, b_retired, mret, mret[3:0]);
      end
    end
    rst = 0; stall = 0; bubble = 0;
  endtask

  initial begin
    rst = 1; stall = 0; bubble = 0;
    nop_in();
    test_reset();
    test_normal_load();
    test_collision();
    test_stall_bubble();
    test_halt();
    test_error();
    test_wrap();
    do_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
